// File: rtl/led_heartbeat_seq.sv
// Heartbeat LED sequencer: one LED (or all, mode 3) blinks BEATS times per step, then the step advances.
// Define HB_PWM_EN to add a duty input that PWM-dims the on-phases.
module led_heartbeat_seq #(
  parameter int N_LED  = 8,
  parameter int PERIOD = 240000,
  parameter int BEATS  = 2,
  parameter int CNT_W  = 32,
  localparam int IDX_W = (N_LED > 1) ? $clog2(N_LED) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
`ifdef HB_PWM_EN
  input  logic [7:0]       duty,
`endif
  output logic [N_LED-1:0] led_out,
  output logic [IDX_W-1:0] cur_idx,
  output logic             step_done
);

  localparam int PHASE = PERIOD / (2 * BEATS);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PHASE - 1);
  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(2 * BEATS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_LED - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO   = '0;

  typedef enum logic [1:0] {
    MODE_UP   = 2'd0,
    MODE_DOWN = 2'd1,
    MODE_PING = 2'd2,
    MODE_ALL  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [CNT_W-1:0] phase_cnt, phase_cnt_nxt;
  logic [CNT_W-1:0] phase_idx, phase_idx_nxt;
  logic [IDX_W-1:0] idx_nxt, adv_idx;
  dir_e             dir_q, dir_nxt, adv_dir;
  mode_e            mode_q, mode_nxt, eff_mode;
  logic             en_q;
  logic             starting, cnt_wrap, step_end, move_up;
  logic [N_LED-1:0] led_nxt, onehot, pattern;
  logic             pwm_on;

`ifdef HB_PWM_EN
  logic [7:0] pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 8'd1;
  end

  assign pwm_on = (pwm_cnt < duty);
`else
  assign pwm_on = 1'b1;
`endif

  // A rising en starts a fresh step whose mode is taken straight from the input.
  always_comb begin
    starting = en && !en_q;
    eff_mode = starting ? mode_e'(mode) : mode_q;
    cnt_wrap = (phase_cnt == CNT_LAST);
    step_end = en && cnt_wrap && (phase_idx == PHASE_LAST);
  end

  assign step_done = step_end;

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N_LED; i++) begin
      onehot[i] = (cur_idx == IDX_W'(i));
    end
    pattern = (eff_mode == MODE_ALL) ? {N_LED{1'b1}} : onehot;
    pattern = pattern & {N_LED{pwm_on}};
  end

  // Index the sequence moves to at the end of the current step; wraps are explicit
  // so N_LED need not be a power of two.
  always_comb begin
    adv_idx = cur_idx;
    adv_dir = dir_q;
    move_up = 1'b0;
    unique case (eff_mode)
      MODE_UP:   adv_idx = (cur_idx == IDX_LAST) ? IDX_ZERO : cur_idx + IDX_W'(1);
      MODE_DOWN: adv_idx = (cur_idx == IDX_ZERO) ? IDX_LAST : cur_idx - IDX_W'(1);
      MODE_PING: begin
        move_up = (dir_q == DIR_UP) ? (cur_idx != IDX_LAST) : (cur_idx == IDX_ZERO);
        if (N_LED > 1) begin
          adv_idx = move_up ? cur_idx + IDX_W'(1) : cur_idx - IDX_W'(1);
          if (adv_idx == IDX_LAST)      adv_dir = DIR_DOWN;
          else if (adv_idx == IDX_ZERO) adv_dir = DIR_UP;
          else                          adv_dir = move_up ? DIR_UP : DIR_DOWN;
        end
      end
      default: adv_idx = cur_idx;
    endcase
  end

  always_comb begin
    phase_cnt_nxt = phase_cnt;
    phase_idx_nxt = phase_idx;
    idx_nxt       = cur_idx;
    dir_nxt       = dir_q;
    mode_nxt      = mode_q;
    led_nxt       = '0;
    if (!en) begin
      phase_cnt_nxt = '0;
      phase_idx_nxt = '0;
    end else begin
      if (starting) begin
        mode_nxt = mode_e'(mode);
        if (mode_nxt == MODE_PING && mode_q != MODE_PING) begin
          dir_nxt = (cur_idx == IDX_LAST) ? DIR_DOWN : DIR_UP;
        end
      end
      led_nxt = (phase_idx[0] == 1'b0) ? pattern : '0;
      if (cnt_wrap) begin
        phase_cnt_nxt = '0;
        phase_idx_nxt = (phase_idx == PHASE_LAST) ? '0 : phase_idx + CNT_W'(1);
      end else begin
        phase_cnt_nxt = phase_cnt + CNT_W'(1);
      end
      // Advance with the mode that governed this step, then adopt the new one.
      if (step_end) begin
        idx_nxt  = adv_idx;
        dir_nxt  = adv_dir;
        mode_nxt = mode_e'(mode);
        if (mode_nxt == MODE_PING && eff_mode != MODE_PING) begin
          dir_nxt = (adv_idx == IDX_LAST) ? DIR_DOWN : DIR_UP;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt <= '0;
      phase_idx <= '0;
      cur_idx   <= '0;
      dir_q     <= DIR_UP;
      mode_q    <= MODE_UP;
      en_q      <= 1'b0;
      led_out   <= '0;
    end else begin
      phase_cnt <= phase_cnt_nxt;
      phase_idx <= phase_idx_nxt;
      cur_idx   <= idx_nxt;
      dir_q     <= dir_nxt;
      mode_q    <= mode_nxt;
      en_q      <= en;
      led_out   <= led_nxt;
    end
  end

endmodule

// File: tb/tb_led_heartbeat_seq.sv
// Randomised and directed checks of led_heartbeat_seq against a step-level reference model.
// Two instances run side by side: N_LED=4/PERIOD=16 and N_LED=1/PERIOD=13 (PHASE truncates to 3).
module tb_led_heartbeat_seq;

  localparam int NA = 4, PA = 16, BA = 2;
  localparam int NB = 1, PB = 13, BB = 2;
  localparam int CW = 8;
  localparam int IWA = 2, IWB = 1;

  logic clk = 1'b0;
  logic rst_n, en;
  logic [1:0] mode;
`ifdef HB_PWM_EN
  logic [7:0] duty;
`endif
  logic [NA-1:0]  led_a;
  logic [IWA-1:0] idx_a;
  logic           done_a;
  logic [NB-1:0]  led_b;
  logic [IWB-1:0] idx_b;
  logic           done_b;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state per instance: position in step, index, ping-pong position, latched mode.
  int m_t[2], m_idx[2], m_p[2], m_mode[2], m_led[2];
  bit m_enq[2];
  int m_pwm;

  always #5 clk = ~clk;

  led_heartbeat_seq #(.N_LED(NA), .PERIOD(PA), .BEATS(BA), .CNT_W(CW)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
`ifdef HB_PWM_EN
    .duty(duty),
`endif
    .led_out(led_a), .cur_idx(idx_a), .step_done(done_a)
  );

  led_heartbeat_seq #(.N_LED(NB), .PERIOD(PB), .BEATS(BB), .CNT_W(CW)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
`ifdef HB_PWM_EN
    .duty(duty),
`endif
    .led_out(led_b), .cur_idx(idx_b), .step_done(done_b)
  );

  function automatic int n_of(int d);
    return (d == 0) ? NA : NB;
  endfunction

  function automatic int ph_of(int d);
    return (d == 0) ? PA / (2 * BA) : PB / (2 * BB);
  endfunction

  function automatic int len_of(int d);
    return (d == 0) ? ph_of(d) * 2 * BA : ph_of(d) * 2 * BB;
  endfunction

  function automatic bit exp_done(int d);
    return rst_n && en && (m_t[d] == len_of(d) - 1);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_t[d] = 0; m_idx[d] = 0; m_p[d] = 0; m_mode[d] = 0; m_led[d] = 0; m_enq[d] = 0;
    end
    m_pwm = 0;
  endtask

  // Ping-pong is modelled as a walk round a ring of 2N-2 positions folded onto 0..N-1.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int n, eff, pw;
      n = n_of(d);
      if (!en) begin
        m_led[d] = 0; m_t[d] = 0; m_enq[d] = 0;
      end else begin
        eff = m_enq[d] ? m_mode[d] : int'(mode);
        if (!m_enq[d]) begin
          if (eff == 2 && m_mode[d] != 2) m_p[d] = m_idx[d];
          m_mode[d] = eff;
        end
        pw = 1;
`ifdef HB_PWM_EN
        pw = (m_pwm < int'(duty)) ? 1 : 0;
`endif
        if (((m_t[d] / ph_of(d)) % 2) == 0 && pw == 1)
          m_led[d] = (eff == 3) ? (1 << n) - 1 : (1 << m_idx[d]);
        else
          m_led[d] = 0;
        if (m_t[d] == len_of(d) - 1) begin
          m_t[d] = 0;
          if (n > 1) begin
            case (eff)
              0: m_idx[d] = (m_idx[d] + 1) % n;
              1: m_idx[d] = (m_idx[d] + n - 1) % n;
              2: begin
                m_p[d]   = (m_p[d] + 1) % (2 * n - 2);
                m_idx[d] = (m_p[d] < n) ? m_p[d] : 2 * n - 2 - m_p[d];
              end
              default: ;
            endcase
          end
          if (int'(mode) == 2 && eff != 2) m_p[d] = m_idx[d];
          m_mode[d] = int'(mode);
        end else begin
          m_t[d]++;
        end
        m_enq[d] = 1;
      end
    end
    m_pwm = (m_pwm + 1) % 256;
  endtask

  task automatic tick();
    if (!rst_n) model_reset();
    else        model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; mode = 2'd0;
    #1;
    model_reset();
    n_cmp++; if (led_a !== 4'b0)  begin n_bad++; $display("[TB] FAIL reset_led_a: got %b want 0000", led_a); end
    n_cmp++; if (idx_a !== 2'd0)  begin n_bad++; $display("[TB] FAIL reset_idx_a: got %0d want 0", idx_a); end
    n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_done_a: got %b want 0", done_a); end
    n_cmp++; if (led_b !== 1'b0)  begin n_bad++; $display("[TB] FAIL reset_led_b: got %b want 0", led_b); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++; if (led_a !== 4'b0)  begin n_bad++; $display("[TB] FAIL idle_led_a: got %b want 0000", led_a); end
    n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("[TB] FAIL idle_done_a: got %b want 0", done_a); end
  endtask

  task automatic test_rotate(input int m);
    int exp_seq[4];
    int n_done;
    if (m == 0) begin exp_seq[0] = 1; exp_seq[1] = 2; exp_seq[2] = 3; exp_seq[3] = 0; end
    else        begin exp_seq[0] = 3; exp_seq[1] = 2; exp_seq[2] = 1; exp_seq[3] = 0; end
    n_done = 0;
    do_reset();
    mode = 2'(m); en = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      tick();
      if (done_a === 1'b1) n_done++;
      n_cmp++; if (led_a !== NA'(m_led[0])) begin n_bad++; $display("[TB] FAIL rot%0d_led c=%0d: got %b want %b", m, c, led_a, NA'(m_led[0])); end
      n_cmp++; if (done_a !== exp_done(0)) begin n_bad++; $display("[TB] FAIL rot%0d_done c=%0d: got %b want %b", m, c, done_a, exp_done(0)); end
      if (c % 16 == 0) begin
        n_cmp++; if (idx_a !== IWA'(exp_seq[c / 16 - 1])) begin n_bad++; $display("[TB] FAIL rot%0d_idx step=%0d: got %0d want %0d", m, c / 16, idx_a, exp_seq[c / 16 - 1]); end
      end
    end
    n_cmp++; if (n_done != 4) begin n_bad++; $display("[TB] FAIL rot%0d_pulses: got %0d want 4", m, n_done); end
  endtask

  task automatic test_ping_pong();
    int exp_seq[8];
    int b_on;
    exp_seq[0] = 1; exp_seq[1] = 2; exp_seq[2] = 3; exp_seq[3] = 2;
    exp_seq[4] = 1; exp_seq[5] = 0; exp_seq[6] = 1; exp_seq[7] = 2;
    b_on = 0;
    do_reset();
    mode = 2'd2; en = 1'b1;
    for (int c = 1; c <= 128; c++) begin
      tick();
      if (led_b === 1'b1) b_on++;
      n_cmp++; if (led_a !== NA'(m_led[0])) begin n_bad++; $display("[TB] FAIL ping_led_a c=%0d: got %b want %b", c, led_a, NA'(m_led[0])); end
      n_cmp++; if (led_b !== NB'(m_led[1])) begin n_bad++; $display("[TB] FAIL ping_led_b c=%0d: got %b want %b", c, led_b, NB'(m_led[1])); end
      n_cmp++; if (idx_b !== 1'b0) begin n_bad++; $display("[TB] FAIL ping_idx_b c=%0d: got %0d want 0", c, idx_b); end
      if (c % 16 == 0) begin
        n_cmp++; if (idx_a !== IWA'(exp_seq[c / 16 - 1])) begin n_bad++; $display("[TB] FAIL ping_idx_a step=%0d: got %0d want %0d", c / 16, idx_a, exp_seq[c / 16 - 1]); end
      end
    end
    n_cmp++; if (b_on == 0) begin n_bad++; $display("[TB] FAIL ping_b_pulse: got %0d on-cycles want >0", b_on); end
  endtask

  task automatic test_mode_latch();
    do_reset();
    mode = 2'd0; en = 1'b1;
    for (int c = 0; c < 37; c++) tick();
    n_cmp++; if (idx_a !== 2'd2) begin n_bad++; $display("[TB] FAIL latch_start_idx: got %0d want 2", idx_a); end
    mode = 2'd3;
    for (int c = 0; c < 11; c++) begin
      tick();
      n_cmp++; if (led_a !== 4'b0000 && led_a !== 4'b0100) begin n_bad++; $display("[TB] FAIL latch_mid_led c=%0d: got %b want 0100 or 0000", c, led_a); end
      n_cmp++; if (led_a !== NA'(m_led[0])) begin n_bad++; $display("[TB] FAIL latch_model_led c=%0d: got %b want %b", c, led_a, NA'(m_led[0])); end
    end
    n_cmp++; if (idx_a !== 2'd3) begin n_bad++; $display("[TB] FAIL latch_next_idx: got %0d want 3", idx_a); end
    tick();
    n_cmp++; if (led_a !== 4'b1111) begin n_bad++; $display("[TB] FAIL latch_all_on: got %b want 1111", led_a); end
    for (int c = 0; c < 15; c++) tick();
    n_cmp++; if (idx_a !== 2'd3) begin n_bad++; $display("[TB] FAIL latch_hold_idx: got %0d want 3", idx_a); end
  endtask

  task automatic test_enable_reset();
    int cnt;
    do_reset();
    mode = 2'd0; en = 1'b1;
    for (int c = 0; c < 22; c++) tick();
    en = 1'b0;
    tick();
    n_cmp++; if (led_a !== 4'b0)  begin n_bad++; $display("[TB] FAIL en_off_led: got %b want 0000", led_a); end
    n_cmp++; if (idx_a !== 2'd1)  begin n_bad++; $display("[TB] FAIL en_off_idx: got %0d want 1", idx_a); end
    n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("[TB] FAIL en_off_done: got %b want 0", done_a); end
    for (int c = 0; c < 3; c++) tick();
    en = 1'b1;
    cnt = 1;
    while (done_a !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    n_cmp++; if (cnt != 16) begin n_bad++; $display("[TB] FAIL en_restart_len: got %0d cycles want 16", cnt); end
    tick();
    n_cmp++; if (idx_a !== 2'd2) begin n_bad++; $display("[TB] FAIL en_restart_idx: got %0d want 2", idx_a); end
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (led_a !== 4'b0)  begin n_bad++; $display("[TB] FAIL midrst_led: got %b want 0000", led_a); end
    n_cmp++; if (idx_a !== 2'd0)  begin n_bad++; $display("[TB] FAIL midrst_idx: got %0d want 0", idx_a); end
    n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_done: got %b want 0", done_a); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    en = 1'b1; mode = 2'($urandom_range(0, 3));
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        en = 1'b1;
      end
      if (en && $urandom_range(0, 99) < 3) en = 1'b0;
      else if (!en && $urandom_range(0, 99) < 30) en = 1'b1;
      if ($urandom_range(0, 99) < 5) mode = 2'($urandom_range(0, 3));
`ifdef HB_PWM_EN
      if ($urandom_range(0, 99) < 5) duty = 8'($urandom_range(0, 255));
`endif
      tick();
      n_cmp++; if (led_a !== NA'(m_led[0]))  begin n_bad++; $display("[TB] FAIL rnd_led_a c=%0d: got %b want %b", c, led_a, NA'(m_led[0])); end
      n_cmp++; if (idx_a !== IWA'(m_idx[0])) begin n_bad++; $display("[TB] FAIL rnd_idx_a c=%0d: got %0d want %0d", c, idx_a, m_idx[0]); end
      n_cmp++; if (done_a !== exp_done(0))   begin n_bad++; $display("[TB] FAIL rnd_done_a c=%0d: got %b want %b", c, done_a, exp_done(0)); end
      n_cmp++; if (led_b !== NB'(m_led[1]))  begin n_bad++; $display("[TB] FAIL rnd_led_b c=%0d: got %b want %b", c, led_b, NB'(m_led[1])); end
      n_cmp++; if (idx_b !== IWB'(m_idx[1])) begin n_bad++; $display("[TB] FAIL rnd_idx_b c=%0d: got %0d want %0d", c, idx_b, m_idx[1]); end
      n_cmp++; if (done_b !== exp_done(1))   begin n_bad++; $display("[TB] FAIL rnd_done_b c=%0d: got %b want %b", c, done_b, exp_done(1)); end
    end
  endtask

`ifdef HB_PWM_EN
  task automatic test_pwm();
    int on_cnt;
    on_cnt = 0;
    do_reset();
    duty = 8'd64; mode = 2'd3; en = 1'b1;
    for (int c = 0; c < 512; c++) begin
      tick();
      if (led_a !== 4'b0) on_cnt++;
      n_cmp++; if (led_a !== NA'(m_led[0])) begin n_bad++; $display("[TB] FAIL pwm64_led c=%0d: got %b want %b", c, led_a, NA'(m_led[0])); end
    end
    n_cmp++; if (on_cnt == 0 || on_cnt > 128) begin n_bad++; $display("[TB] FAIL pwm64_count: got %0d on-cycles want 1..128", on_cnt); end
    duty = 8'd0;
    for (int c = 0; c < 64; c++) begin
      tick();
      n_cmp++; if (led_a !== 4'b0) begin n_bad++; $display("[TB] FAIL pwm0_led c=%0d: got %b want 0000", c, led_a); end
    end
    duty = 8'd255;
  endtask
`endif

  initial begin
    rst_n = 1'b1; en = 1'b0; mode = 2'd0;
`ifdef HB_PWM_EN
    duty = 8'd255;
`endif
    model_reset();
    #2;
    test_reset();
`ifndef HB_PWM_EN
    test_rotate(0);
    test_rotate(1);
    test_ping_pong();
    test_mode_latch();
    test_enable_reset();
`else
    test_pwm();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_heartbeat_seq.md
Name: led_heartbeat_seq

Overview:
Parametrised heartbeat LED sequencer. Drives N_LED outputs: one active LED (or all, in mode 3) blinks BEATS times per step, then the sequence advances to the next LED.
- Step sequence is up, down or ping-pong, selected at runtime.
- Sits between the board clock domain and the LED pins, alongside the other LED mode drivers.

Parameters:
N_LED, 8, number of LED outputs (>=1)
PERIOD, 240000, clock cycles per step; must be >= 2*BEATS
BEATS, 2, on/off pulse pairs per step (>=1)
CNT_W, 32, phase counter width; must hold PERIOD/(2*BEATS)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
en  in  1  run enable
mode  in  2  0=rotate up, 1=rotate down, 2=ping-pong, 3=all LEDs beat together
led_out  out  N_LED  LED drive, 1=on
cur_idx  out  $clog2(N_LED) (min 1)  index of active LED
step_done  out  1  one-cycle pulse on the last cycle of each step

Behaviour:
- Reset values: led_out=0, cur_idx=0, step_done=0, phase counter=0, phase index=0, ping-pong direction=up, latched mode=0.
- Timing derivation:
  - PHASE = PERIOD/(2*BEATS), integer division; remainder is dropped.
  - A step is 2*BEATS phases of PHASE cycles.
  - Even phases (0,2,..) are on; odd phases are off.
- Output registration: led_out is registered. Value during on-phase cycle k reflects the counter state of cycle k-1, giving one cycle of latency, constant.
- On-phase output:
  - Modes 0-2: led_out = one-hot(cur_idx).
  - Mode 3: led_out = all ones.
- Off-phase output: led_out = 0.
- Phase counter:
  - Counts 0..PHASE-1, then wraps and increments the phase index.
  - The phase index wraps after 2*BEATS-1; that cycle is the end of the step.
- At end of step:
  - step_done=1 for exactly that cycle.
  - cur_idx advances per the latched mode.
  - mode input is sampled into the latched mode; mode changes never take effect mid-step.
- Mode 0: cur_idx = cur_idx+1, wraps N_LED-1 -> 0.
- Mode 1: cur_idx = cur_idx-1, wraps 0 -> N_LED-1.
- Mode 2 (ping-pong):
  - Moves by direction; at N_LED-1 the direction flips to down, at 0 it flips to up.
  - Endpoints are not repeated: e.g. N_LED=4 gives 0,1,2,3,2,1,0,1...
  - N_LED=1: cur_idx stays 0.
- Mode 3: cur_idx unchanged.
- Switching into mode 2: direction resets to up, unless cur_idx=N_LED-1, in which case it resets to down.
- en=0:
  - Next clock: led_out=0, phase counter and phase index cleared, step_done=0.
  - cur_idx, direction and latched mode are held.
  - When en returns to 1, the mode input is latched at once and a fresh step starts at phase 0 on the held cur_idx.
- Reset mid-step: all state returns to reset values immediately (asynchronous); no partial step completes.
- All counter compares are done at CNT_W width. cur_idx arithmetic wraps explicitly, never by natural overflow, so N_LED need not be a power of 2.

Optional Feature:
Macro HB_PWM_EN.
- Defined:
  - Adds input port duty[7:0] and a free-running 8-bit PWM counter, reset to 0.
  - During on-phases, active bits of led_out are 1 only while pwm_cnt < duty.
  - duty=0: LEDs always off. duty=255: off 1 of 256 cycles.
  - Off-phases and en=0 behave unchanged.
  - duty is sampled every cycle, with no latching.
- Not defined: no duty port and no PWM counter; on-phases drive full-on.

Test Plan:
1. Step timing, mode 0: N_LED=4, PERIOD=16, BEATS=2, en=1 after reset. Per step, led_out sequence is 0001 x4, 0000 x4, 0001 x4, 0000 x4. step_done pulses every 16 cycles. cur_idx goes 0,1,2,3,0.
2. Mode 1 and wrap: same parameters, mode=1. cur_idx goes 0,3,2,1,0; active bit matches cur_idx in on-phases.
3. Ping-pong: mode=2, N_LED=4, run 8 steps. cur_idx goes 0,1,2,3,2,1,0,1. Same test with N_LED=1: cur_idx stays 0 and led_out pulses bit 0.
4. Mode latching and all-on: change mode 0->3 mid-step at cur_idx=2. Remainder of that step stays one-hot 0100. The next step shows 1111 during on-phases, and cur_idx holds at 3.
5. Enable and reset mid-step:
   - Drop en at phase 1, cycle 2: led_out=0 next cycle and cur_idx holds. Raising en restarts at phase 0 on the same index (full 16-cycle step before step_done).
   - Assert rst_n=0 mid-step: all outputs 0 immediately.
6. HB_PWM_EN defined, duty=64: during on-phases, the active LED is high for exactly 64 of every 256 cycles. duty=0 gives led_out=0 throughout.
